ip_rx_cr_coalesce: RTL and testbench



---
 rtl/ip_rx_cr_coalesce.sv | 176 +++++++++++++++++
 tb/tb_ip_rx_cr_coalesce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ip_rx_cr_coalesce.sv
// RX credit return coalescer: header/NPD credits are returned one per cycle,
// posted-data credits are batched and released on threshold, timeout or flush.
module ip_rx_cr_coalesce #(
    parameter int unsigned c_PD_THRESH = 16,
    parameter int unsigned c_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_ph_cr,
    input  logic       in_pd_cr,
    input  logic [7:0] in_pd_num,
    input  logic       in_nph_cr,
    input  logic       in_npd_cr,
    input  logic       cr_hold,
    input  logic       flush,
    output logic       ph_cr,
    output logic       nph_cr,
    output logic       npd_cr,
    output logic       pd_cr,
    output logic [7:0] pd_num,
    output logic       flush_done,
    output logic       err_ovf
);

    localparam logic [11:0] PD_THRESH = 12'(c_PD_THRESH);
    localparam logic [11:0] TMO       = 12'(c_TIMEOUT);

    typedef enum logic [1:0] {
        e_IDLE,
        e_ACCUM,
        e_FLUSH
    } state_t;

    // Returns {overflow, next_count}; saturates at 255 and drops the excess.
    function automatic logic [8:0] hdr_next(input logic [7:0] cnt,
                                            input logic       dec,
                                            input logic       inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} - {8'd0, dec} + {8'd0, inc};
        if (sum[8]) hdr_next = {1'b1, 8'hFF};
        else        hdr_next = {1'b0, sum[7:0]};
    endfunction

    // Returns {overflow, next_acc}; saturates at 4095.
    function automatic logic [12:0] acc_next(input logic [11:0] acc,
                                             input logic [7:0]  dec,
                                             input logic [5:0]  inc);
        logic [12:0] sum;
        sum = {1'b0, acc} - {5'd0, dec} + {7'd0, inc};
        if (sum[12]) acc_next = {1'b1, 12'hFFF};
        else         acc_next = {1'b0, sum[11:0]};
    endfunction

    // DW length to 4-DW credits; a zero length field means 128 DW.
    function automatic logic [5:0] pd_credits(input logic [6:0] len_dw);
        logic [7:0] len;
        logic [7:0] rnd;
        len = (len_dw == 7'd0) ? 8'd128 : {1'b0, len_dw};
        rnd = len + 8'd3;
        pd_credits = rnd[7:2];
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  ph_cnt_q, ph_cnt_d;
    logic [7:0]  nph_cnt_q, nph_cnt_d;
    logic [7:0]  npd_cnt_q, npd_cnt_d;
    logic [11:0] pd_acc_q, pd_acc_d;
    logic [11:0] pd_tmr_q, pd_tmr_d;
    logic        ph_cr_q, ph_cr_d;
    logic        nph_cr_q, nph_cr_d;
    logic        npd_cr_q, npd_cr_d;
    logic        pd_cr_q, pd_cr_d;
    logic [7:0]  pd_num_q, pd_num_d;
    logic        flush_done_q, flush_done_d;
    logic        err_ovf_q, err_ovf_d;

    logic        ovf_ph, ovf_nph, ovf_npd, ovf_pd;
    logic [5:0]  pd_inc;
    logic        any_in;
    logic        unused_pd_num_msb;

    assign unused_pd_num_msb = in_pd_num[7];

    always_comb begin
        ph_cr_d      = 1'b0;
        nph_cr_d     = 1'b0;
        npd_cr_d     = 1'b0;
        pd_cr_d      = 1'b0;
        pd_num_d     = 8'd0;
        flush_done_d = 1'b0;
        state_d      = state_q;
        pd_inc       = in_pd_cr ? pd_credits(in_pd_num[6:0]) : 6'd0;
        any_in       = in_ph_cr | in_pd_cr | in_nph_cr | in_npd_cr;

        if (!cr_hold) begin
            ph_cr_d  = (ph_cnt_q != 8'd0);
            nph_cr_d = (nph_cnt_q != 8'd0);
            npd_cr_d = (npd_cnt_q != 8'd0);
            pd_cr_d  = (pd_acc_q != 12'd0) &&
                       ((pd_acc_q >= PD_THRESH) || (pd_tmr_q == TMO) ||
                        (state_q == e_FLUSH));
        end
        if (pd_cr_d) pd_num_d = (pd_acc_q > 12'd255) ? 8'hFF : pd_acc_q[7:0];

        {ovf_ph,  ph_cnt_d}  = hdr_next(ph_cnt_q,  ph_cr_d,  in_ph_cr);
        {ovf_nph, nph_cnt_d} = hdr_next(nph_cnt_q, nph_cr_d, in_nph_cr);
        {ovf_npd, npd_cnt_d} = hdr_next(npd_cnt_q, npd_cr_d, in_npd_cr);
        {ovf_pd,  pd_acc_d}  = acc_next(pd_acc_q, pd_num_d, pd_inc);
        err_ovf_d = err_ovf_q | ovf_ph | ovf_nph | ovf_npd | ovf_pd;

        // Timer measures how long a non-empty accumulator has gone without a release.
        if (pd_cr_d || (pd_acc_d == 12'd0)) pd_tmr_d = 12'd0;
        else if (pd_tmr_q == TMO)           pd_tmr_d = pd_tmr_q;
        else                                pd_tmr_d = pd_tmr_q + 12'd1;

        case (state_q)
            e_IDLE: begin
                if (flush)                     state_d = e_FLUSH;
                else if (pd_acc_d != 12'd0)    state_d = e_ACCUM;
            end
            e_ACCUM: begin
                if (flush)                     state_d = e_FLUSH;
                else if (pd_acc_d == 12'd0)    state_d = e_IDLE;
            end
            e_FLUSH: begin
                if (!cr_hold && !any_in && (ph_cnt_q == 8'd0) && (nph_cnt_q == 8'd0) &&
                    (npd_cnt_q == 8'd0) && (pd_acc_q == 12'd0)) begin
                    flush_done_d = 1'b1;
                    state_d      = e_IDLE;
                end
            end
            default: state_d = e_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= e_IDLE;
            ph_cnt_q     <= 8'd0;
            nph_cnt_q    <= 8'd0;
            npd_cnt_q    <= 8'd0;
            pd_acc_q     <= 12'd0;
            pd_tmr_q     <= 12'd0;
            ph_cr_q      <= 1'b0;
            nph_cr_q     <= 1'b0;
            npd_cr_q     <= 1'b0;
            pd_cr_q      <= 1'b0;
            pd_num_q     <= 8'd0;
            flush_done_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_cnt_q     <= ph_cnt_d;
            nph_cnt_q    <= nph_cnt_d;
            npd_cnt_q    <= npd_cnt_d;
            pd_acc_q     <= pd_acc_d;
            pd_tmr_q     <= pd_tmr_d;
            ph_cr_q      <= ph_cr_d;
            nph_cr_q     <= nph_cr_d;
            npd_cr_q     <= npd_cr_d;
            pd_cr_q      <= pd_cr_d;
            pd_num_q     <= pd_num_d;
            flush_done_q <= flush_done_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign ph_cr      = ph_cr_q;
    assign nph_cr     = nph_cr_q;
    assign npd_cr     = npd_cr_q;
    assign pd_cr      = pd_cr_q;
    assign pd_num     = pd_num_q;
    assign flush_done = flush_done_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_ip_rx_cr_coalesce.sv
// Directed bench for ip_rx_cr_coalesce: cycle-by-cycle vector table plus
// hand-written timeout, hold, flush and overflow/reset sequences.
module tb_ip_rx_cr_coalesce;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_ph_cr, in_pd_cr, in_nph_cr, in_npd_cr;
    logic [7:0] in_pd_num;
    logic       cr_hold, flush;
    logic       ph_cr, nph_cr, npd_cr, pd_cr;
    logic [7:0] pd_num;
    logic       flush_done, err_ovf;

    int tests = 0;
    int fails = 0;

    ip_rx_cr_coalesce #(.c_PD_THRESH(16), .c_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .in_ph_cr(in_ph_cr), .in_pd_cr(in_pd_cr), .in_pd_num(in_pd_num),
        .in_nph_cr(in_nph_cr), .in_npd_cr(in_npd_cr),
        .cr_hold(cr_hold), .flush(flush),
        .ph_cr(ph_cr), .nph_cr(nph_cr), .npd_cr(npd_cr),
        .pd_cr(pd_cr), .pd_num(pd_num),
        .flush_done(flush_done), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Expected output packing: {ph, nph, npd, pd, pd_num[7:0], flush_done, err_ovf}
    typedef struct {
        logic       rst, ph, pd;
        logic [7:0] num;
        logic       nph, npd, hold, fl;
        logic [13:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic r, input logic ph, input logic pd, input logic [7:0] num,
                                input logic nph, input logic npd, input logic hold, input logic fl,
                                input logic e_ph, input logic e_nph, input logic e_npd, input logic e_pd,
                                input logic [7:0] e_num, input logic e_fd, input logic e_err);
        vec_t v;
        v.rst = r; v.ph = ph; v.pd = pd; v.num = num;
        v.nph = nph; v.npd = npd; v.hold = hold; v.fl = fl;
        v.exp = {e_ph, e_nph, e_npd, e_pd, e_num, e_fd, e_err};
        vt.push_back(v);
    endfunction

    function automatic logic [13:0] outs();
        return {ph_cr, nph_cr, npd_cr, pd_cr, pd_num, flush_done, err_ovf};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 1'b0; in_ph_cr = 1'b0; in_pd_cr = 1'b0; in_pd_num = 8'd0;
        in_nph_cr = 1'b0; in_npd_cr = 1'b0; cr_hold = 1'b0; flush = 1'b0;
    endtask

    initial begin
        int cnt, nph_n, fd_n, rc, early;
        logic [7:0] rel [0:15];

        clr();
        rst = 1'b1;

        //   rst ph pd num    nph npd hold fl | ph nph npd pd num    fd err
        add(1, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 0 reset
        add(1, 1, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 1 input under reset dropped
        add(0, 1, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 2
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   1, 0, 0, 0, 8'd0,  0, 0); // 3 ph two edges later
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 4
        add(0, 1, 0, 8'd0,  1, 1, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 5
        add(0, 1, 0, 8'd0,  0, 0, 0, 0,   1, 1, 1, 0, 8'd0,  0, 0); // 6 back-to-back
        add(0, 1, 0, 8'd0,  0, 0, 0, 0,   1, 0, 0, 0, 8'd0,  0, 0); // 7
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   1, 0, 0, 0, 8'd0,  0, 0); // 8
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 9
        add(0, 0, 1, 8'd16, 0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 10 4 credits
        add(0, 0, 1, 8'd16, 0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 11
        add(0, 0, 1, 8'd16, 0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 12
        add(0, 0, 1, 8'd16, 0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 13 acc reaches 16
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 1, 8'd16, 0, 0); // 14 threshold release
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 15
        add(0, 0, 1, 8'h80, 0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 16 len 0 -> 128 DW (bit7 ignored)
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 1, 8'd32, 0, 0); // 17
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 18
        add(0, 0, 1, 8'd13, 0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 19 13 DW -> 4
        add(0, 0, 1, 8'd50, 0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 20 50 DW -> 13
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 1, 8'd17, 0, 0); // 21
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 22
        add(0, 1, 0, 8'd0,  0, 0, 1, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 23 hold
        add(0, 0, 0, 8'd0,  0, 0, 1, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 24
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   1, 0, 0, 0, 8'd0,  0, 0); // 25 return on hold drop edge
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 26
        add(0, 0, 0, 8'd0,  0, 0, 0, 1,   0, 0, 0, 0, 8'd0,  0, 0); // 27 empty flush
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  1, 0); // 28 flush_done
        add(0, 0, 0, 8'd0,  0, 0, 0, 0,   0, 0, 0, 0, 8'd0,  0, 0); // 29

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; in_ph_cr = vt[i].ph; in_pd_cr = vt[i].pd; in_pd_num = vt[i].num;
            in_nph_cr = vt[i].nph; in_npd_cr = vt[i].npd; cr_hold = vt[i].hold; flush = vt[i].fl;
            tick();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
        end
        clr();
        tick();

        // Timeout: 2 credits, released exactly 255 edges after the update.
        in_pd_cr = 1'b1; in_pd_num = 8'd5;
        tick();
        clr();
        early = 0;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (pd_cr) early++;
        end
        chk("tmo_early", 32'(early), 32'd0);
        tick();
        chk("tmo_release", {23'd0, pd_cr, pd_num}, {23'd0, 1'b1, 8'd2});
        tick();
        chk("tmo_after", {23'd0, pd_cr, pd_num}, 32'd0);

        // Hold: 3 NPH and 70 x 32 PD credits accumulated, then drained.
        cnt = 0;
        cr_hold = 1'b1;
        for (int i = 0; i < 75; i++) begin
            in_pd_cr  = (i < 70);
            in_pd_num = 8'd0;
            in_nph_cr = (i == 10 || i == 30 || i == 50);
            tick();
            if (ph_cr | nph_cr | npd_cr | pd_cr | flush_done) cnt++;
        end
        clr();
        chk("hold_quiet", 32'(cnt), 32'd0);
        nph_n = 0; fd_n = 0; rc = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (nph_cr) nph_n++;
            if (flush_done) fd_n++;
            if (pd_cr) begin
                if (rc < 16) rel[rc] = pd_num;
                rc++;
            end
        end
        chk("hold_nph", 32'(nph_n), 32'd3);
        chk("hold_pd_count", 32'(rc), 32'd9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("hold_pd%0d", i), 32'(rel[i]), (i < 8) ? 32'd255 : 32'd200);
        chk("hold_no_fd", 32'(fd_n), 32'd0);
        chk("hold_no_err", 32'(err_ovf), 32'd0);

        // Flush with ph=2, npd=1, pd=3 pending; second flush during drain ignored.
        cr_hold = 1'b1;
        in_ph_cr = 1'b1; in_npd_cr = 1'b1; in_pd_cr = 1'b1; in_pd_num = 8'd9;
        tick();
        in_npd_cr = 1'b0; in_pd_cr = 1'b0; in_pd_num = 8'd0;
        tick();
        in_ph_cr = 1'b0; flush = 1'b1;
        tick();
        chk("fl_held", 32'(outs()), 32'd0);
        cr_hold = 1'b0; flush = 1'b1;
        tick();
        chk("fl_drain1", 32'(outs()), 32'({1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0}));
        flush = 1'b0;
        tick();
        chk("fl_drain2", 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}));
        tick();
        chk("fl_done", 32'(outs()), 32'({4'b0000, 8'd0, 1'b1, 1'b0}));
        tick();
        chk("fl_done_1cyc", 32'(outs()), 32'd0);

        // Overflow: 300 PH under hold saturate at 255.
        cr_hold = 1'b1; in_ph_cr = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        in_ph_cr = 1'b0;
        tick();
        chk("ovf_set", 32'(err_ovf), 32'd1);
        cr_hold = 1'b0;
        cnt = 0;
        for (int i = 0; i < 270; i++) begin
            tick();
            if (ph_cr) cnt++;
        end
        chk("ovf_drain", 32'(cnt), 32'd255);
        chk("ovf_sticky", 32'(err_ovf), 32'd1);

        // Reset in the middle of a drain discards pending credits.
        cr_hold = 1'b1; in_ph_cr = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        in_ph_cr = 1'b0; cr_hold = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_ph", 32'(ph_cr), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_outs", 32'(outs()), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ph_cr) cnt++;
        end
        chk("rst_discard", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
